canvas_stream: RTL and testbench
================================

# canvas_stream

Pixel-fetch stage between the display timing generator and the board colour-expansion logic. It takes the raster position stream (x, y, de, frame) and fetches packed indexed pixels from synchronous bitmap memory, applying integer scaling and window placement. It resolves each pixel through an internal RGB palette and emits the position stream, delayed three cycles, with RGB at system bits per channel (BG_COLR outside the window).

## Interface
- CORDW, 16: signed coordinate width.
- BPC, 5: bits per colour channel; palette entry is 3*BPC bits, {r,g,b}.
- CANV_BPP, 4: bits per canvas pixel; legal 1, 2, 4, 8; PPW = 16/CANV_BPP pixels per 16-bit word.
- CANV_SCALE, 2: integer scale factor, ≥1.
- WIN_WIDTH, 672 / WIN_HEIGHT, 384: window size in display pixels/lines; WIN_WIDTH divisible by CANV_SCALE*PPW.
- WIN_STARTX, 0 / WIN_STARTY, 0: window top-left in display coordinates.
- BG_COLR, 'h0886: colour outside window, 3*BPC bits.
- ADDRW, 16: bitmap word address width.
- FILE_PAL, "": optional palette init file (hex); empty means palette powers up zero.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- disp_x, disp_y  in  CORDW signed  raster position.
- disp_de  in  1  data enable.
- disp_frame  in  1  one-cycle frame-start pulse.
- bmap_addr  out  ADDRW  bitmap word read address.
- bmap_data  in  16  bitmap word, valid one cycle after bmap_addr.
- pal_we  in  1  palette write strobe.
- pal_addr  in  CANV_BPP  palette write index.
- pal_data  in  3*BPC  palette write colour.
- out_x, out_y  out  CORDW signed  disp_x/disp_y delayed 3.
- out_de, out_frame  out  1  disp_de/disp_frame delayed 3.
- out_r, out_g, out_b  out  BPC  pixel colour.

## Operation
- In-window: WIN_STARTX ≤ x < WIN_STARTX+WIN_WIDTH and WIN_STARTY ≤ y < WIN_STARTY+WIN_HEIGHT and disp_de, signed compare.
- State: hsub (0..SCALE-1), cx (canvas column), vsub (0..SCALE-1), line_base (word address of current canvas row).
- Horizontal: cx and hsub are 0 whenever input is not in-window. Each in-window cycle uses current cx, then hsub increments; at SCALE-1, hsub←0 and cx←cx+1.
- Vertical: on in-window x = WIN_STARTX+WIN_WIDTH-1, vsub increments. At SCALE-1, vsub←0 and line_base←line_base + WIN_WIDTH/(SCALE*PPW). Otherwise line_base holds, so the row repeats.
- disp_frame=1 clears vsub, line_base, hsub and cx; it takes priority over any same-cycle update.
- Word address = line_base + cx/PPW. Pixel index = cx mod PPW; pixel 0 occupies bits [CANV_BPP-1:0].
- Palette: 2^CANV_BPP entries, one synchronous write port, not touched by reset. A same-cycle write and read of one entry returns the old value.
- Out-of-window pixels output BG_COLR. No bitmap value affects them.

## Timing
- Input at cycle n drives bmap_addr registered at n+1. bmap_data is sampled at n+2, and the pixel is selected and palette-read. Outputs are registered at n+3.
- Latency is fixed at 3 for every signal; no stalls and no backpressure.
- bmap_addr holds its last value while out of window.
- Reset (asserted): all outputs, bmap_addr, counters and pipeline registers are 0, including out_r/g/b and out_de. After release, the first 3 output cycles reflect pipeline zeros.
- Reset mid-frame: counters restart at canvas row 0. Correct row alignment resumes at the next disp_frame.
- Rows past WIN_HEIGHT never advance line_base because they are not in-window.

## Test plan
- Parameters WIN 16x4 at (0,0), SCALE 2, BPP 4. Bitmap word 0 = 'h3210, palette i→{i,i,i}. Drive frame, then y=0 x=0..15 -> out_r sequence 0,0,1,1,2,2,3,3 starting exactly 3 cycles after x=0. bmap_addr = 0,0,…,1 at x=8.
- Same setup, lines y=0..3 -> bmap_addr base 0 for y=0,1 and 2 for y=2,3. Line-base step = 16/(2*4) = 2.
- WIN_STARTX=4, WIN_STARTY=2 -> x=3 or y=1 outputs BG_COLR 'h0886. x=4,y=2 outputs palette[pixel 0 of word 0].
- Write pal_addr=1, pal_data='h7FFF on the same cycle its lookup occurs -> old colour output. The next lookup gives r=g=b=31.
- Assert rst low mid-line -> all outputs 0 immediately (asynchronous). After release and disp_frame, the first window pixel reads word 0.
- disp_frame coincident with the last in-window pixel of a row -> line_base=0, vsub=0 afterwards.

Source files
------------

// File: rtl/canvas_stream_if.sv
// Bitmap memory read bus between canvas_stream and its synchronous bitmap RAM.
// The address is issued by the fetch stage; data returns one cycle later.
interface canvas_stream_if #(
   parameter int ADDRW = 16
);
   logic [ADDRW-1:0] bmap_addr;
   logic [15:0]      bmap_data;

   modport master (output bmap_addr, input bmap_data);
   modport slave  (input bmap_addr, output bmap_data);
endinterface

// File: rtl/canvas_stream.sv
// Pixel-fetch stage: maps the raster position stream onto a scaled canvas
// window, fetches packed indexed pixels from bitmap memory, resolves them
// through an internal palette and re-emits the position stream three cycles
// later with colour attached (background colour outside the window).
module canvas_stream #(
   parameter int               CORDW      = 16,
   parameter int               BPC        = 5,
   parameter int               CANV_BPP   = 4,
   parameter int               CANV_SCALE = 2,
   parameter int               WIN_WIDTH  = 672,
   parameter int               WIN_HEIGHT = 384,
   parameter int               WIN_STARTX = 0,
   parameter int               WIN_STARTY = 0,
   parameter logic [3*BPC-1:0] BG_COLR    = 'h0886,
   parameter int               ADDRW      = 16,
   parameter string            FILE_PAL   = ""
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [CORDW-1:0] disp_x,
   input  logic signed [CORDW-1:0] disp_y,
   input  logic                    disp_de,
   input  logic                    disp_frame,
   canvas_stream_if.master         bmap,
   input  logic                    pal_we,
   input  logic [CANV_BPP-1:0]     pal_addr,
   input  logic [3*BPC-1:0]        pal_data,
   output logic signed [CORDW-1:0] out_x,
   output logic signed [CORDW-1:0] out_y,
   output logic                    out_de,
   output logic                    out_frame,
   output logic [BPC-1:0]          out_r,
   output logic [BPC-1:0]          out_g,
   output logic [BPC-1:0]          out_b
);

   localparam int PPW  = 16 / CANV_BPP;
   localparam int PIXW = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int SUBW = (CANV_SCALE > 1) ? $clog2(CANV_SCALE) : 1;
   localparam int COLW = 3 * BPC;

   localparam logic [ADDRW-1:0] ROW_STEP = ADDRW'(WIN_WIDTH / (CANV_SCALE * PPW));
   localparam logic [SUBW-1:0]  SUB_LAST = SUBW'(CANV_SCALE - 1);

   localparam logic signed [CORDW-1:0] X_LO   = CORDW'(WIN_STARTX);
   localparam logic signed [CORDW-1:0] X_HI   = CORDW'(WIN_STARTX + WIN_WIDTH);
   localparam logic signed [CORDW-1:0] X_LAST = CORDW'(WIN_STARTX + WIN_WIDTH - 1);
   localparam logic signed [CORDW-1:0] Y_LO   = CORDW'(WIN_STARTY);
   localparam logic signed [CORDW-1:0] Y_HI   = CORDW'(WIN_STARTY + WIN_HEIGHT);

   // canvas position state
   logic [SUBW-1:0]  hsub, vsub;
   logic [ADDRW-1:0] cx, line_base;
   logic             in_win;

   // pipeline stage 1 (address issued) and stage 2 (bitmap data valid)
   logic signed [CORDW-1:0] s1_x, s1_y, s2_x, s2_y;
   logic                    s1_de, s1_frame, s1_win, s2_de, s2_frame, s2_win;
   logic [PIXW-1:0]         s1_pix, s2_pix;

   logic [COLW-1:0]     pal_mem [0:(1 << CANV_BPP) - 1];
   logic [CANV_BPP-1:0] pix_idx;
   logic [COLW-1:0]     colr;

   // window membership of the current raster position (signed compare)
   always_comb begin
      in_win = disp_de && (disp_x >= X_LO) && (disp_x < X_HI)
                       && (disp_y >= Y_LO) && (disp_y < Y_HI);
   end

   // horizontal/vertical scaling counters; frame start overrides everything
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hsub      <= '0;
         cx        <= '0;
         vsub      <= '0;
         line_base <= '0;
      end else if (disp_frame) begin
         hsub      <= '0;
         cx        <= '0;
         vsub      <= '0;
         line_base <= '0;
      end else if (in_win) begin
         if (hsub == SUB_LAST) begin
            hsub <= '0;
            cx   <= cx + ADDRW'(1);
         end else begin
            hsub <= hsub + SUBW'(1);
         end
         if (disp_x == X_LAST) begin
            if (vsub == SUB_LAST) begin
               vsub      <= '0;
               line_base <= line_base + ROW_STEP;
            end else begin
               vsub <= vsub + SUBW'(1);
            end
         end
      end else begin
         hsub <= '0;
         cx   <= '0;
      end
   end

   // bitmap address issue and position pipeline; address holds outside window
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bmap.bmap_addr <= '0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_de    <= 1'b0;
         s1_frame <= 1'b0;
         s1_win   <= 1'b0;
         s1_pix   <= '0;
         s2_x     <= '0;
         s2_y     <= '0;
         s2_de    <= 1'b0;
         s2_frame <= 1'b0;
         s2_win   <= 1'b0;
         s2_pix   <= '0;
      end else begin
         if (in_win) bmap.bmap_addr <= line_base + (cx >> PIXW);
         s1_x     <= disp_x;
         s1_y     <= disp_y;
         s1_de    <= disp_de;
         s1_frame <= disp_frame;
         s1_win   <= in_win;
         s1_pix   <= cx[PIXW-1:0];
         s2_x     <= s1_x;
         s2_y     <= s1_y;
         s2_de    <= s1_de;
         s2_frame <= s1_frame;
         s2_win   <= s1_win;
         s2_pix   <= s1_pix;
      end
   end

   // palette write port; contents survive reset
   always_ff @(posedge clk) begin
      if (pal_we) pal_mem[pal_addr] <= pal_data;
   end

   // pixel select from the returned word and palette lookup; the lookup is
   // sampled on the same edge as a write, so a colliding write returns old data
   always_comb begin
      pix_idx = CANV_BPP'(bmap.bmap_data >> (s2_pix * CANV_BPP));
      colr    = s2_win ? pal_mem[pix_idx] : BG_COLR;
   end

   // registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_x     <= '0;
         out_y     <= '0;
         out_de    <= 1'b0;
         out_frame <= 1'b0;
         out_r     <= '0;
         out_g     <= '0;
         out_b     <= '0;
      end else begin
         out_x     <= s2_x;
         out_y     <= s2_y;
         out_de    <= s2_de;
         out_frame <= s2_frame;
         out_r     <= colr[3*BPC-1 -: BPC];
         out_g     <= colr[2*BPC-1 -: BPC];
         out_b     <= colr[BPC-1:0];
      end
   end

endmodule

// File: tb/tb_canvas_stream.sv
// Bench for canvas_stream: two instances (window at (0,0) and at (4,2)) share
// one raster stream; each has its own bitmap RAM model and scoreboard queue.
module tb_canvas_stream;

   localparam int          WW    = 16;
   localparam int          WH    = 4;
   localparam int          SCALE = 2;
   localparam int          PPW   = 4;
   localparam logic [14:0] BG    = 15'h0886;

   typedef struct {
      int                 cyc;
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic               fr;
      logic               vld;
      logic               bg;
      int                 word;
      logic [3:0]         idx;
      logic [14:0]        colr;
   } rec_t;

   logic clk, rst;
   logic signed [15:0] disp_x, disp_y;
   logic disp_de, disp_frame;
   logic pal_we;
   logic [3:0]  pal_addr;
   logic [14:0] pal_data;

   logic signed [15:0] out_x_a, out_y_a, out_x_b, out_y_b;
   logic out_de_a, out_frame_a, out_de_b, out_frame_b;
   logic [4:0] out_r_a, out_g_a, out_b_a, out_r_b, out_g_b, out_b_b;

   logic [15:0] mem [16];
   logic [14:0] pal_m [16];
   rec_t qa [$];
   rec_t qb [$];
   rec_t pa [2];
   rec_t pb [2];
   int last_a, last_b;
   int cyc;
   int n_chk, n_fail;

   canvas_stream_if #(.ADDRW(16)) bus_a ();
   canvas_stream_if #(.ADDRW(16)) bus_b ();

   canvas_stream #(
      .CORDW(16), .BPC(5), .CANV_BPP(4), .CANV_SCALE(SCALE),
      .WIN_WIDTH(WW), .WIN_HEIGHT(WH), .WIN_STARTX(0), .WIN_STARTY(0),
      .BG_COLR(BG), .ADDRW(16), .FILE_PAL("")
   ) dut_a (
      .clk(clk), .rst(rst), .disp_x(disp_x), .disp_y(disp_y),
      .disp_de(disp_de), .disp_frame(disp_frame), .bmap(bus_a.master),
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
      .out_x(out_x_a), .out_y(out_y_a), .out_de(out_de_a), .out_frame(out_frame_a),
      .out_r(out_r_a), .out_g(out_g_a), .out_b(out_b_a)
   );

   canvas_stream #(
      .CORDW(16), .BPC(5), .CANV_BPP(4), .CANV_SCALE(SCALE),
      .WIN_WIDTH(WW), .WIN_HEIGHT(WH), .WIN_STARTX(4), .WIN_STARTY(2),
      .BG_COLR(BG), .ADDRW(16), .FILE_PAL("")
   ) dut_b (
      .clk(clk), .rst(rst), .disp_x(disp_x), .disp_y(disp_y),
      .disp_de(disp_de), .disp_frame(disp_frame), .bmap(bus_b.master),
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
      .out_x(out_x_b), .out_y(out_y_b), .out_de(out_de_b), .out_frame(out_frame_b),
      .out_r(out_r_b), .out_g(out_g_b), .out_b(out_b_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // synchronous bitmap RAMs, one-cycle read latency
   always @(posedge clk) bus_a.bmap_data <= mem[bus_a.bmap_addr[3:0]];
   always @(posedge clk) bus_b.bmap_data <= mem[bus_b.bmap_addr[3:0]];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // expected response for a window at (wx,wy): direct canvas-coordinate formula
   function automatic rec_t model(input int wx, input int wy, input int x, input int y,
                                  input logic de, input logic fr, input int c);
      rec_t r;
      int cx, row;
      r.cyc = c; r.x = 16'(x); r.y = 16'(y); r.fr = fr; r.vld = de;
      r.bg = !(de && x >= wx && x < wx + WW && y >= wy && y < wy + WH);
      r.word = 0; r.idx = '0; r.colr = BG;
      if (!r.bg) begin
         cx     = (x - wx) / SCALE;
         row    = (y - wy) / SCALE;
         r.word = row * (WW / (SCALE * PPW)) + cx / PPW;
         r.idx  = 4'(mem[r.word] >> (4 * (cx % PPW)));
      end
      return r;
   endfunction

   function automatic rec_t resolve(input rec_t r);
      r.colr = r.bg ? BG : pal_m[r.idx];
      return r;
   endfunction

   // one raster cycle; colour of each input is fixed at its palette-lookup cycle
   task automatic step(input int x, input int y, input logic de, input logic fr,
                       input logic we = 1'b0, input logic [3:0] wa = '0,
                       input logic [14:0] wd = '0);
      rec_t ra, rb;
      disp_x = 16'(x); disp_y = 16'(y); disp_de = de; disp_frame = fr;
      pal_we = we; pal_addr = wa; pal_data = wd;
      @(posedge clk); #1;
      ra = model(0, 0, x, y, de, fr, cyc);
      rb = model(4, 2, x, y, de, fr, cyc);
      if (!ra.bg) last_a = ra.word;
      if (!rb.bg) last_b = rb.word;
      chk("bmap_addr_a", 64'(bus_a.bmap_addr), 64'(last_a));
      chk("bmap_addr_b", 64'(bus_b.bmap_addr), 64'(last_b));
      if (pa[1].vld) qa.push_back(resolve(pa[1]));
      if (pb[1].vld) qb.push_back(resolve(pb[1]));
      if (we) pal_m[wa] = wd;
      pa[1] = pa[0]; pa[0] = ra;
      pb[1] = pb[0]; pb[0] = rb;
   endtask

   task automatic line(input int y, input int fr_at = -1, input int wr_at = -1);
      for (int x = 0; x < 22; x++)
         step(x, y, 1'b1, x == fr_at, x == wr_at, 4'd1, 15'h7FFF);
      repeat (2) step(0, y, 1'b0, 1'b0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_a"}, 64'({out_x_a, out_y_a, out_de_a, out_frame_a, out_r_a, out_g_a, out_b_a, bus_a.bmap_addr}), 64'(0));
      chk({tag, "_b"}, 64'({out_x_b, out_y_b, out_de_b, out_frame_b, out_r_b, out_g_b, out_b_b, bus_b.bmap_addr}), 64'(0));
   endtask

   task automatic check_rec(input string tag, input rec_t r, input logic signed [15:0] x,
                            input logic signed [15:0] y, input logic fr,
                            input logic [4:0] rr, input logic [4:0] gg, input logic [4:0] bb);
      chk({tag, "_pos"}, 64'({x, y, fr}), 64'({r.x, r.y, r.fr}));
      chk({tag, "_rgb"}, 64'({rr, gg, bb}), 64'(r.colr));
      chk({tag, "_latency"}, 64'(cyc), 64'(r.cyc + 2));
   endtask

   // scoreboard monitors: compare every valid output against the queue head
   always @(negedge clk) begin
      rec_t r;
      if (rst && out_de_a) begin
         if (qa.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL a_extra: got output x=%0d y=%0d, expected none", out_x_a, out_y_a);
         end else begin
            r = qa.pop_front();
            check_rec("a", r, out_x_a, out_y_a, out_frame_a, out_r_a, out_g_a, out_b_a);
         end
      end
   end

   always @(negedge clk) begin
      rec_t r;
      if (rst && out_de_b) begin
         if (qb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL b_extra: got output x=%0d y=%0d, expected none", out_x_b, out_y_b);
         end else begin
            r = qb.pop_front();
            check_rec("b", r, out_x_b, out_y_b, out_frame_b, out_r_b, out_g_b, out_b_b);
         end
      end
   end

   initial begin
      n_chk = 0; n_fail = 0; last_a = 0; last_b = 0;
      for (int i = 0; i < 16; i++) begin
         mem[i]   = 16'h5A5A;
         pal_m[i] = '0;
      end
      mem[0] = 16'h3210; mem[1] = 16'h7654; mem[2] = 16'hBA98; mem[3] = 16'hFEDC;
      for (int i = 0; i < 2; i++) begin
         pa[i].vld = 1'b0; pb[i].vld = 1'b0;
      end
      rst = 1'b0; disp_x = '0; disp_y = '0; disp_de = 1'b0; disp_frame = 1'b0;
      pal_we = 1'b0; pal_addr = '0; pal_data = '0;

      // reset state
      #12;
      chk_zero("reset_state");
      #10 rst = 1'b1;

      // palette i -> {i,i,i}
      for (int i = 0; i < 16; i++)
         step(0, 0, 1'b0, 1'b0, 1'b1, 4'(i), {5'(i), 5'(i), 5'(i)});

      // frame 1: scaled fetch, row stepping, background, colliding palette write
      step(0, 0, 1'b0, 1'b1);
      line(0);
      line(1, -1, 4);
      for (int y = 2; y < 6; y++) line(y);

      // frame 2: frame pulse on the last in-window pixel of a row
      step(0, 0, 1'b0, 1'b1);
      line(0);
      line(1, 15);
      for (int y = 0; y < 4; y++) line(y);

      // asynchronous reset mid-line
      step(0, 0, 1'b0, 1'b1);
      for (int x = 0; x < 7; x++) step(x, 0, 1'b1, 1'b0);
      #3 rst = 1'b0;
      #1;
      chk_zero("async_reset");
      qa.delete(); qb.delete();
      for (int i = 0; i < 2; i++) begin
         pa[i].vld = 1'b0; pb[i].vld = 1'b0;
      end
      last_a = 0; last_b = 0;
      disp_de = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      chk_zero("reset_held");
      rst = 1'b1;
      step(0, 0, 1'b0, 1'b1);
      line(0);
      line(1);

      // drain
      repeat (3) step(0, 0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      #1;
      chk("drain_a", 64'(qa.size()), 64'(0));
      chk("drain_b", 64'(qb.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
